ckmux_ctrl: RTL and testbench
=============================

# ckmux_ctrl

Switch sequencer that drives the `select` input of the glitch-free clock mux and confirms that the muxed clock is running on the requested source. It runs on a free-running control clock, accepts switch requests through a valid/ready handshake, holds `select` stable for a settle window, then counts toggles of a divide-by-2 heartbeat generated in the muxed-clock domain. It reports completion, or a watchdog error, with a one-cycle `done` pulse. It sits in the clocking block beside the mux, between the system controller and the mux.

## Interface
- `SETTLE_CYCLES`, default 8: `clk` cycles `select` is held before heartbeat checking starts; legal range 1..2^CNT_W-1.
- `CHECK_EDGES`, default 4: synchronized heartbeat edges required to confirm the switch; legal range 1..255.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit, counted from SETTLE entry; only used with `CKMUX_CTRL_TIMEOUT_EN`.
- `CNT_W`, default 16: width of the settle/watchdog counter.
- `clk`  input  1  control clock, free-running, independent of both mux sources.
- `rst`  input  1  reset. One clock; reset is asynchronous and active-high.
- `req_valid`  input  1  switch request valid.
- `req_sel`  input  1  requested source: 0 = clk0, 1 = clk1.
- `req_ready`  output  1  request accepted when `req_valid && req_ready`.
- `mon_tog`  input  1  heartbeat from a toggle flop clocked by `out_clk`; asynchronous to `clk`.
- `select`  output  1  registered, drives the mux `select`.
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  valid with `done`; 1 = watchdog expired.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- Reset values: state = IDLE, `select` = 0, `req_ready` = 1, `busy` = 0, `done` = 0, `err` = 0, all counters = 0, sync flops = 0.
- While `rst` is high, `req_valid` is ignored.
- `req_ready` = (state == IDLE), combinational from the state register. `busy` is its inverse.
- IDLE, request accepted with `req_sel == select`: go to DONE with `err` = 0. `select` is not touched.
- IDLE, request accepted with `req_sel != select`: `select <= req_sel` and go to SETTLE. Clear the settle and edge counters.
- SETTLE: the settle counter increments every cycle. When it reaches SETTLE_CYCLES-1, go to CHECK.
- Heartbeat path:
  - `mon_tog` passes through a 2-flop synchronizer, then one delay flop.
  - An edge is detected when the delay flop differs from the synchronizer output; both rising and falling edges count.
  - Edges are counted only in CHECK.
- CHECK: when the edge count reaches CHECK_EDGES, go to DONE with `err` = 0.
- DONE: lasts exactly one cycle with `done` = 1, then returns to IDLE. `err` is 0 outside DONE.
- `select` changes only on an IDLE acceptance. An error never reverts it.
- `req_valid` deasserting after acceptance has no effect.
- Asserting `rst` mid-switch forces IDLE and `select` = 0 immediately. No `done` is produced for the aborted request.

## Timing
- Acceptance in cycle N:
  - `select` flips at N+1.
  - SETTLE covers N+1 .. N+SETTLE_CYCLES.
  - CHECK starts at N+SETTLE_CYCLES+1.
- Heartbeat toggle to counted edge: 3 `clk` cycles of synchronizer latency. Edges arriving during SETTLE are not counted.
- Minimum latency from acceptance to `done`, switch case: SETTLE_CYCLES + CHECK_EDGES + 1 cycles (heartbeat toggling every cycle).
- No-op request accepted at N: `done` = 1 at N+1; `req_ready` = 1 again at N+2.
- Back-to-back requests: the next acceptance is possible in the cycle after DONE.

## Configuration
- `CKMUX_CTRL_TIMEOUT_EN` defined:
  - A watchdog counts from SETTLE entry.
  - If it reaches TIMEOUT_CYCLES while in SETTLE or CHECK, go to DONE with `err` = 1.
  - If the edge target and the timeout hit in the same cycle, the edge target wins (`err` = 0).
- Not defined: no watchdog logic exists, CHECK waits indefinitely, and `err` is tied 0.

## Test plan
- Reset, then `req_sel`=1 at cycle 5, `mon_tog` toggling every cycle, defaults -> `select`=1 at cycle 6; `done`=1, `err`=0 at cycle 18 or later; `req_ready`=0 from cycle 6 until `done`.
- `req_sel`=0 while `select`=0 -> `done`=1, `err`=0 the next cycle; `select` stays 0; no SETTLE entry.
- `mon_tog` held constant, TIMEOUT_EN defined, TIMEOUT_CYCLES=64 -> `done`=1, `err`=1 exactly 64 cycles after SETTLE entry; `select` retains the new value.
- Same stimulus without the macro -> no `done` within 10000 cycles; `busy` stays 1.
- `rst` asserted for 1 cycle during CHECK -> `select`=0, `busy`=0, `req_ready`=1 immediately; no `done` pulse.
- `mon_tog` toggling every 5 cycles, CHECK_EDGES=4 -> `done` within 20+3 cycles of CHECK entry; edges from SETTLE not counted.

Source files
------------

// File: rtl/ckmux_ctrl.sv
// Switch sequencer for the glitch-free clock mux: settle, then confirm heartbeat.
// Define CKMUX_CTRL_TIMEOUT_EN to build the watchdog that ends a stuck switch with err.
module ckmux_ctrl #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int CHECK_EDGES    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic mon_tog,
    output logic select,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       EDGE_LAST   = 8'(CHECK_EDGES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       edges;
    logic             sync1;
    logic             sync2;
    logic             tog_d;
    logic             accept;
    logic             hb_edge;
    logic             edge_hit;
    logic             settle_hit;
    logic             timeout;

    assign req_ready  = (state == IDLE);
    assign busy       = ~req_ready;
    assign accept     = req_valid & req_ready;
    assign hb_edge    = sync2 ^ tog_d;
    assign edge_hit   = hb_edge && (edges == EDGE_LAST);
    assign settle_hit = (cnt == SETTLE_LAST);

`ifdef CKMUX_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // cnt runs from SETTLE entry through CHECK, so it doubles as the watchdog
    assign timeout = (cnt == TIMEOUT_LAST);
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    // mon_tog is asynchronous to clk; both heartbeat edges count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            tog_d <= 1'b0;
        end else begin
            sync1 <= mon_tog;
            sync2 <= sync1;
            tog_d <= sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            select <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            edges  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_sel == select) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            select <= req_sel;
                            cnt    <= '0;
                            edges  <= '0;
                            state  <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (timeout) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (settle_hit) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
`ifdef CKMUX_CTRL_TIMEOUT_EN
                    cnt <= cnt + CNT_W'(1);
`endif
                    if (hb_edge) begin
                        edges <= edges + 8'd1;
                    end
                    // reaching the edge target beats a same-cycle timeout
                    if (edge_hit) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (timeout) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ckmux_ctrl.sv
// Bench for ckmux_ctrl: directed table, scripted corner cases and random traffic
// checked against a timeline model computed from the heartbeat history.
module tb_ckmux_ctrl;

    localparam int S     = 8;
    localparam int E     = 4;
    localparam int T     = 64;
    localparam int MAXC  = 10100;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_sel = 1'b0;
    logic mon_tog = 1'b0;
    logic req_ready;
    logic select;
    logic busy;
    logic done;
    logic err;

    ckmux_ctrl #(
        .SETTLE_CYCLES(S),
        .CHECK_EDGES(E),
        .TIMEOUT_CYCLES(T),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_sel(req_sel),
        .req_ready(req_ready),
        .mon_tog(mon_tog),
        .select(select),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    int cur_t = 0;
    int first_done = -1;

    bit mon_a [MAXC];
    bit rv_a [MAXC];
    bit rs_a [MAXC];

    typedef struct {
        logic       v;
        logic       s;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0d got %0h want %0h", name, cur_t, act, exp);
        end
    endtask

    function automatic bit monv(input int i);
        if (i < 0) return 1'b0;
        return mon_a[i];
    endfunction

    // a counted edge in cycle u comes from a mon_tog change between cycles u-3 and u-2
    function automatic bit edge_at(input int u);
        return monv(u - 2) != monv(u - 3);
    endfunction

    function automatic void sched_switch(input int n, output int d, output bit e);
        int cnt;
        int te;
        cnt = 0;
        te = -1;
        for (int u = n + S + 1; u < MAXC && te < 0; u++) begin
            if (edge_at(u)) begin
                cnt++;
                if (cnt == E) te = u;
            end
        end
        d = (te < 0) ? NEVER : te + 1;
        e = 1'b0;
`ifdef CKMUX_CTRL_TIMEOUT_EN
        if (n + 1 + T < d) begin
            d = n + 1 + T;
            e = 1'b1;
        end
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b1;
        req_sel = 1'b1;
        mon_tog = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_sel = 1'b0;
        rst = 1'b0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            mon_a[i] = 1'b0;
            rv_a[i] = 1'b0;
            rs_a[i] = 1'b0;
        end
    endtask

    task automatic run_engine(input int n);
        bit m_idle;
        bit m_sel;
        bit pend;
        bit m_err;
        bit xd;
        int sel_at;
        int busy_from;
        int done_at;
        m_idle = 1'b1;
        m_sel = 1'b0;
        pend = 1'b0;
        m_err = 1'b0;
        sel_at = -100;
        busy_from = -100;
        done_at = -100;
        first_done = -1;
        for (int t = 0; t < n; t++) begin
            cur_t = t;
            if (t == sel_at) m_sel = pend;
            if (t == busy_from) m_idle = 1'b0;
            if (t == done_at + 1) m_idle = 1'b1;
            xd = (t == done_at);
            chk("outs", {27'd0, req_ready, busy, select, done, err},
                {27'd0, m_idle, !m_idle, m_sel, xd, xd && m_err});
            if (done === 1'b1 && first_done < 0) first_done = t;
            req_valid = rv_a[t];
            req_sel = rs_a[t];
            mon_tog = mon_a[t];
            if (m_idle && rv_a[t]) begin
                busy_from = t + 1;
                if (rs_a[t] == m_sel) begin
                    done_at = t + 1;
                    m_err = 1'b0;
                end else begin
                    pend = rs_a[t];
                    sel_at = t + 1;
                    sched_switch(t, done_at, m_err);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // {ready, busy, select, done, err} seen in the cycle the inputs are applied
        tbl[0] = '{1'b0, 1'b0, 5'b10000};
        tbl[1] = '{1'b1, 1'b0, 5'b10000};
        tbl[2] = '{1'b0, 1'b0, 5'b01010};
        tbl[3] = '{1'b1, 1'b0, 5'b10000};
        tbl[4] = '{1'b1, 1'b0, 5'b01010};
        tbl[5] = '{1'b0, 1'b0, 5'b10000};
        tbl[6] = '{1'b1, 1'b1, 5'b10000};
        tbl[7] = '{1'b0, 1'b0, 5'b01100};
        tbl[8] = '{1'b1, 1'b0, 5'b01100};
        tbl[9] = '{1'b0, 1'b0, 5'b01100};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            cur_t = i;
            chk("tbl", {27'd0, req_ready, busy, select, done, err},
                {27'd0, tbl[i].exp});
            req_valid = tbl[i].v;
            req_sel = tbl[i].s;
            @(negedge clk);
        end

        // heartbeat toggling every cycle: minimum switch latency
        do_reset();
        clear_stim();
        for (int i = 0; i < MAXC; i++) mon_a[i] = i[0];
        rv_a[5] = 1'b1;
        rs_a[5] = 1'b1;
        run_engine(30);
        chk("min_latency_done", first_done, 18);

        // heartbeat every 5 cycles: edge inside SETTLE must be ignored
        do_reset();
        clear_stim();
        for (int i = 0; i < MAXC; i++) mon_a[i] = ((i / 5) % 2) != 0;
        rv_a[2] = 1'b1;
        rs_a[2] = 1'b1;
        run_engine(40);
        chk("slow_hb_done", first_done, 28);

        // dead heartbeat
        do_reset();
        clear_stim();
        rv_a[2] = 1'b1;
        rs_a[2] = 1'b1;
`ifdef CKMUX_CTRL_TIMEOUT_EN
        run_engine(80);
        chk("timeout_done", first_done, 67);
        chk("timeout_sel_kept", {31'd0, select}, 32'd1);
`else
        run_engine(10000);
        chk("no_timeout_done", first_done, -1);
        chk("no_timeout_busy", {31'd0, busy}, 32'd1);
`endif

        // reset in the middle of CHECK
        do_reset();
        clear_stim();
        rv_a[2] = 1'b1;
        rs_a[2] = 1'b1;
        run_engine(15);
        rst = 1'b1;
        #1;
        chk("abort_sel", {31'd0, select}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_stim();
        run_engine(30);
        chk("abort_no_done", first_done, -1);

        // random traffic
        do_reset();
        clear_stim();
        mon_a[0] = 1'($urandom_range(0, 1));
        for (int i = 1; i < MAXC; i++) begin
            mon_a[i] = mon_a[i-1] ^ ($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < MAXC; i++) begin
            rv_a[i] = ($urandom_range(0, 2) == 0);
            rs_a[i] = 1'($urandom_range(0, 1));
        end
        run_engine(3000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
